// File: rtl/cpu_pkg.sv
// Shared processor parameters used by the register file, ALU and control unit.
package cpu_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int ZERO_REG   = 0;

endpackage : cpu_pkg

// File: rtl/regfile_register32.sv
// One storage word of the register file: enable-gated D flip-flop bank with
// asynchronous active-low clear.
module register32 #(
  parameter int W = cpu_pkg::DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Storage word: cleared asynchronously, loaded only when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule : register32

// File: rtl/regfile.sv
// Two-read, one-write register file with a hard-wired zero register and
// combinational (unbypassed) read ports.
module regfile #(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int NUM_REGS = cpu_pkg::NUM_REGS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           RegWrite,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] WriteRegister,
  input  logic [DATA_W-1:0]              WriteData,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] ReadRegister1,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] ReadRegister2,
  output logic [DATA_W-1:0]              ReadData1,
  output logic [DATA_W-1:0]              ReadData2
);

  import cpu_pkg::*;

  logic [NUM_REGS-1:0] w_we;
  logic [DATA_W-1:0]   w_regs [NUM_REGS];
  logic [DATA_W-1:0]   w_rd1;
  logic [DATA_W-1:0]   w_rd2;

  // One-hot write-enable decoder; the zero register can never be enabled.
  always_comb begin
    w_we = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_we[i] = RegWrite & (WriteRegister == REG_ADDR_W'(i));
    end
    w_we[ZERO_REG] = 1'b0;
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_word
    register32 #(.W(DATA_W)) u_word (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (w_we[g]),
      .i_d   (WriteData),
      .o_q   (w_regs[g])
    );
  end

  // Read multiplexers: storage only, so a same-cycle write is seen after the edge.
  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_rd1 = (ReadRegister1 == REG_ADDR_W'(i)) ? w_regs[i] : w_rd1;
      w_rd2 = (ReadRegister2 == REG_ADDR_W'(i)) ? w_regs[i] : w_rd2;
    end
  end

  assign ReadData1 = w_rd1;
  assign ReadData2 = w_rd2;

endmodule : regfile

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register and data-port width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 32, meaning number of architectural registers; address width is log2(NUM_REGS), which is 5 at default.
REQ-003 SHALL have port clk  input  1  meaning single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning reset, asynchronous, active-low.
REQ-005 SHALL have port RegWrite  input  1  meaning write enable.
REQ-006 SHALL have port WriteRegister  input  5  meaning write address.
REQ-007 SHALL have port WriteData  input  DATA_W  meaning write data.
REQ-008 SHALL have port ReadRegister1  input  5  meaning read port 1 address.
REQ-009 SHALL have port ReadRegister2  input  5  meaning read port 2 address.
REQ-010 SHALL have port ReadData1  output  DATA_W  meaning port 1 data, which drives ALU BussA.
REQ-011 SHALL have port ReadData2  output  DATA_W  meaning port 2 data, which drives ALU BussB.

Function
REQ-012 SHALL implement NUM_REGS registers, each DATA_W wide; register 0 SHALL read 0 at all times.
REQ-013 SHALL provide combinational reads: ReadDataN equals the current contents of register ReadRegisterN within the same cycle (zero-cycle latency).
REQ-014 SHALL, on a rising clk edge with RegWrite=1 and WriteRegister!=0, load WriteData into register WriteRegister; the value becomes visible on the read ports after that edge.
REQ-015 SHALL ignore writes to register 0 (no state change, no error).
REQ-016 SHALL leave all registers unchanged on any edge with RegWrite=0, whatever WriteRegister and WriteData are.
REQ-017 SHALL have no write-to-read bypass: a read of the address being written in the same cycle returns the old value until the edge, so no combinational loop forms through the ALU.
REQ-018 SHALL allow both read ports to address the same register, including register 0, simultaneously with identical results.
REQ-019 SHALL write exactly one register per edge; only the addressed register changes.
REQ-020 SHALL produce no X on the read ports after reset for any address.

Reset
REQ-021 SHALL clear all registers to 0 immediately when rst_n falls, independent of clk.
REQ-022 SHALL hold all registers at 0 and block all writes while rst_n=0, including a write coincident with the assertion of reset.
REQ-023 SHALL accept writes starting from the first rising clk edge after rst_n rises.
REQ-024 SHALL, while in reset, drive ReadData1=0 and ReadData2=0 for all addresses.

Structure
REQ-025 SHALL take DATA_W, REG_ADDR_W=5, NUM_REGS=32 and ZERO_REG=0 from the shared processor package cpu_pkg, which the ALU and control unit also use.
REQ-026 SHALL build each storage word from the sub-module register32: a DATA_W-wide, enable-gated D flip-flop bank with async active-low clear.
REQ-027 SHALL generate the write enables with a 5-to-32 one-hot decoder qualified by RegWrite, with bit 0 forced low.
REQ-028 SHALL implement each read port as a 32:1 DATA_W-wide multiplexer.

Verification
REQ-029 SHALL cover: write R1=0x00000DEF and R2=0x00000ABC on consecutive edges, then read R1 on port 1 and R2 on port 2 -> ReadData1=0x00000DEF, ReadData2=0x00000ABC; feeding the ALU with ALUControl=00 gives 0x000018AB.
REQ-030 SHALL cover: RegWrite=1, WriteRegister=0, WriteData=0xFFFFFFFF, then read R0 on both ports -> both read 0x00000000.
REQ-031 SHALL cover: R5=0x7FFFFFFF, then in one cycle write R5=0x00000001 while reading R5 -> old 0x7FFFFFFF before the edge and 0x00000001 after it.
REQ-032 SHALL cover: RegWrite=0 with WriteRegister=3 and WriteData=0x80000000 -> R3 keeps its prior value of 0x00001234.
REQ-033 SHALL cover: write Ri=i*0x01010101 for i=1..31, then sweep both ports -> every register reads its own pattern, with no aliasing.
REQ-034 SHALL cover: with R7=0x00001234 loaded, assert rst_n=0 mid-cycle away from the clk edge -> ReadData reads 0 immediately; a RegWrite to R7 during reset is dropped; after release R7 reads 0.
